// File: rtl/dff_bank_arbiter.sv
// Two-requester round-robin arbiter driving an external WIDTH-bit flop bank (load / set-mask / clear-mask / read).
// Optional rdata_par output when DFF_BANK_PARITY_EN is defined.
module dff_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
`ifdef DFF_BANK_PARITY_EN
    output logic             rdata_par,
`endif
    output logic             busy,
    input  logic [WIDTH-1:0] bank_q,
    output logic [WIDTH-1:0] bank_d,
    output logic [WIDTH-1:0] bank_set_n,
    output logic [WIDTH-1:0] bank_clr_n
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] ISSUE   = 2'b01;
    localparam logic [1:0] CAPTURE = 2'b10;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

`ifdef DFF_BANK_PARITY_EN
    localparam int CAP_W = WIDTH + 1;
`else
    localparam int CAP_W = WIDTH;
`endif

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             last_reg;
    logic             id_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] set_n_reg;
    logic [WIDTH-1:0] clr_n_reg;
    logic [WIDTH-1:0] set_n_next;
    logic [WIDTH-1:0] clr_n_next;
    logic             done_reg;
    logic [CAP_W-1:0] cap_reg;
    logic [CAP_W-1:0] cap_next;

    logic             win_valid;
    logic             win_id;
    logic [1:0]       win_op;
    logic [WIDTH-1:0] win_data;
    logic             accept;
    logic             set_arm;
    logic             clr_arm;
    logic             load_active;

    // last_reg holds the id granted last; on a tie the other requester wins.
    always_comb begin
        win_valid = req0 | req1;
        win_id    = (req0 && req1) ? ~last_reg : req1;
        win_op    = win_id ? op1 : op0;
        win_data  = win_id ? data1 : data0;
    end

    assign accept      = (state_reg == IDLE) && win_valid;
    assign set_arm     = accept && (win_op == OP_SET);
    assign clr_arm     = accept && (win_op == OP_CLR);
    assign load_active = (state_reg == ISSUE) && (op_reg == OP_LOAD);

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = win_valid ? ISSUE : IDLE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Set/clear strobes are registered at acceptance so they are live for exactly the ISSUE cycle.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign set_n_next[gi] = ~(set_arm & win_data[gi]);
            assign clr_n_next[gi] = ~(clr_arm & win_data[gi]);
            assign bank_d[gi]     = load_active ? data_reg[gi] : bank_q[gi];
        end
    endgenerate

`ifdef DFF_BANK_PARITY_EN
    assign cap_next = {^bank_q, bank_q};
`else
    assign cap_next = bank_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            id_reg    <= 1'b0;
            op_reg    <= OP_LOAD;
            data_reg  <= '0;
            set_n_reg <= '1;
            clr_n_reg <= '1;
            done_reg  <= 1'b0;
            cap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            set_n_reg <= set_n_next;
            clr_n_reg <= clr_n_next;
            done_reg  <= 1'b0;
            if (accept) begin
                id_reg   <= win_id;
                last_reg <= win_id;
                op_reg   <= win_op;
                data_reg <= win_data;
            end
            if (state_reg == CAPTURE) begin
                cap_reg  <= cap_next;
                done_reg <= 1'b1;
            end
        end
    end

    assign gnt0       = (state_reg == ISSUE) && !id_reg;
    assign gnt1       = (state_reg == ISSUE) && id_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign rdata      = cap_reg[WIDTH-1:0];
    assign bank_set_n = set_n_reg;
    assign bank_clr_n = clr_n_reg;
`ifdef DFF_BANK_PARITY_EN
    assign rdata_par  = cap_reg[WIDTH];
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: behavioural flop bank, monitor with rdata scoreboard, directed and random ops.
// Connects rdata_par when DFF_BANK_PARITY_EN is defined.
module tb_dff_bank_arbiter;

    localparam int W = 8;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [1:0]   op0 = 2'b00, op1 = 2'b00;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic         gnt0, gnt1, done, busy;
    logic [W-1:0] rdata, bank_q, bank_d, bank_set_n, bank_clr_n;
`ifdef DFF_BANK_PARITY_EN
    logic         rdata_par;
`endif

    logic         force_en = 1'b1;
    logic [W-1:0] force_val = '0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_bank = '0;
    logic [W-1:0] exp_q[$];
    int           due = 0;
    logic         exp_done;
    logic [1:0]   m_op;
    logic [W-1:0] m_d;
    logic [W-1:0] exp_rd;

    dff_bank_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .done(done), .rdata(rdata),
`ifdef DFF_BANK_PARITY_EN
        .rdata_par(rdata_par),
`endif
        .busy(busy), .bank_q(bank_q), .bank_d(bank_d),
        .bank_set_n(bank_set_n), .bank_clr_n(bank_clr_n)
    );

    always #5 clk = ~clk;

    // External bank: no reset, clear dominates set; force path lets the bench preset contents.
    always @(posedge clk) begin
        if (force_en) begin
            bank_q <= force_val;
        end else begin
            for (int i = 0; i < W; i++)
                bank_q[i] <= !bank_clr_n[i] ? 1'b0 : (!bank_set_n[i] ? 1'b1 : bank_d[i]);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: every grant pushes the modelled post-op bank value, every done pops and compares it.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            exp_q.delete();
            due = 0;
        end else begin
            check_eq("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
            exp_done = (due == 1);
            if (due > 0) due--;
            check_eq("done_timing", {31'd0, done}, {31'd0, exp_done});
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_rd = exp_q.pop_front();
                    check_eq("rdata", {24'd0, rdata}, {24'd0, exp_rd});
`ifdef DFF_BANK_PARITY_EN
                    check_eq("rdata_par", {31'd0, rdata_par}, {31'd0, ^exp_rd});
`endif
                end
            end
            if (gnt0 || gnt1) begin
                m_op = gnt1 ? op1 : op0;
                m_d  = gnt1 ? data1 : data0;
                case (m_op)
                    OP_LOAD: begin
                        check_eq("load_d", {24'd0, bank_d}, {24'd0, m_d});
                        check_eq("load_strobes", {16'd0, bank_set_n, bank_clr_n}, 32'h0000FFFF);
                        model_bank = m_d;
                    end
                    OP_SET: begin
                        check_eq("set_n", {24'd0, bank_set_n}, {24'd0, ~m_d});
                        check_eq("set_clr_n", {24'd0, bank_clr_n}, 32'h000000FF);
                        model_bank = model_bank | m_d;
                    end
                    OP_CLR: begin
                        check_eq("clr_n", {24'd0, bank_clr_n}, {24'd0, ~m_d});
                        check_eq("clr_set_n", {24'd0, bank_set_n}, 32'h000000FF);
                        model_bank = model_bank & ~m_d;
                    end
                    default: begin
                        check_eq("read_strobes", {16'd0, bank_set_n, bank_clr_n}, 32'h0000FFFF);
                        check_eq("read_hold", {24'd0, bank_d}, {24'd0, bank_q});
                    end
                endcase
                exp_q.push_back(model_bank);
                due = 2;
            end
        end
    end

    task automatic drive_req(input bit id, input bit val, input logic [1:0] op, input logic [W-1:0] d);
        if (id) begin
            req1 = val; op1 = op; data1 = d;
        end else begin
            req0 = val; op0 = op; data0 = d;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 6);
        check_eq("done_seen", {31'd0, done}, 32'd1);
    endtask

    // Request at a negedge must be granted at the very next edge (idle or done cycle).
    task automatic run_op(input bit id, input logic [1:0] op, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        drive_req(id, 1'b1, op, d);
        do begin
            @(posedge clk); #1; n++;
        end while (!(gnt0 || gnt1) && n < 10);
        check_eq("gnt_latency", 32'(n), 32'd1);
        check_eq("gnt_id", {30'd0, gnt1, gnt0}, id ? 32'd2 : 32'd1);
        @(negedge clk);
        drive_req(id, 1'b0, op, d);
        wait_done();
    endtask

    task automatic bank_preset(input logic [W-1:0] v);
        @(negedge clk);
        force_en = 1'b1; force_val = v;
        @(negedge clk);
        force_en = 1'b0;
        model_bank = v;
    endtask

    initial begin
        int n;
        int gid[4];
        int gcyc[4];
        int ng;

        #1 rst = 1'b1;
        #1;
        check_eq("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check_eq("rst_done_busy", {30'd0, done, busy}, 32'd0);
        check_eq("rst_rdata", {24'd0, rdata}, 32'd0);
        check_eq("rst_strobes", {16'd0, bank_set_n, bank_clr_n}, 32'h0000FFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        force_en = 1'b0;
        model_bank = '0;

        run_op(1'b0, OP_LOAD, 8'hA5);
        run_op(1'b1, OP_SET, 8'h0F);
        run_op(1'b1, OP_CLR, 8'hA0);
        run_op(1'b0, OP_SET, 8'h00);
        run_op(1'b1, OP_CLR, 8'h00);

        // Reset in the middle of the ISSUE cycle of LOAD 0xFF.
        @(negedge clk);
        drive_req(1'b0, 1'b1, OP_LOAD, 8'hFF);
        @(posedge clk); #1;
        check_eq("abort_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_gnt_rst", {30'd0, gnt1, gnt0}, 32'd0);
        check_eq("abort_done_busy", {30'd0, done, busy}, 32'd0);
        check_eq("abort_rdata", {24'd0, rdata}, 32'd0);
        check_eq("abort_strobes", {16'd0, bank_set_n, bank_clr_n}, 32'h0000FFFF);
        @(negedge clk);
        drive_req(1'b0, 1'b0, OP_LOAD, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_bank = bank_q;
        run_op(1'b0, OP_READ, 8'h00);

        // READ of preset bank; req1 raised while busy must wait for the done-cycle edge.
        bank_preset(8'h3C);
        @(negedge clk);
        drive_req(1'b0, 1'b1, OP_READ, 8'h00);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!gnt0 && n < 10);
        check_eq("r34_gnt0", 32'(n), 32'd1);
        @(negedge clk);
        drive_req(1'b0, 1'b0, OP_READ, 8'h00);
        drive_req(1'b1, 1'b1, OP_READ, 8'h00);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!gnt1 && n < 8);
        check_eq("r34_req1_defer", 32'(n), 32'd3);
        @(negedge clk);
        drive_req(1'b1, 1'b0, OP_READ, 8'h00);
        wait_done();

        // Both requesters held high from reset: strict alternation, one grant per 3 cycles.
        @(negedge clk);
        rst = 1'b1;
        drive_req(1'b0, 1'b1, OP_READ, 8'h00);
        drive_req(1'b1, 1'b1, OP_READ, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ng = 0;
        for (int c = 1; c <= 14 && ng < 4; c++) begin
            @(posedge clk); #1;
            if (gnt0 || gnt1) begin
                gid[ng] = gnt1 ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
        end
        check_eq("rr_count", 32'(ng), 32'd4);
        if (ng == 4) begin
            check_eq("rr_first_cycle", 32'(gcyc[0]), 32'd1);
            for (int k = 0; k < 4; k++) begin
                check_eq("rr_id", 32'(gid[k]), 32'(k % 2));
                if (k > 0) check_eq("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
            end
        end
        @(negedge clk);
        drive_req(1'b0, 1'b0, OP_READ, 8'h00);
        drive_req(1'b1, 1'b0, OP_READ, 8'h00);
        wait_done();

        for (int k = 0; k < 8; k++)
            run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
